// File: rtl/sirv_pmu_pkg.sv
// Shared types and key constants for the AON PMU lock/sleep-write sequencers.
package sirv_pmu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    KEY_UNL,
    CHECK,
    WRITE,
    KEY_LCK,
    RESP
  } pmu_init_state_e;

  localparam logic [31:0] PMU_UNLOCK_KEY = 32'h0051_F15E;
  localparam logic [31:0] PMU_LOCK_KEY   = 32'h0000_0000;

endpackage

// File: rtl/sirv_pmu_timeout_cnt.sv
// Clear/enable cycle counter; tc_o flags the enabled cycle on which the count reaches TIMEOUT.
module sirv_pmu_timeout_cnt #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Independent of clr_i so the owner may derive its clear from this flag.
  assign tc_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/sirv_pmu_unlock_initiator.sv
// Runs one PMU sleep command: unlock key, wait for unlocked status, sleep write, re-lock key.
// Optional macro PMU_INIT_RETRY_EN: retry the unlock once after the first status timeout.
module sirv_pmu_unlock_initiator
  import sirv_pmu_pkg::*;
#(
  parameter logic [31:0] UNLOCK_KEY = PMU_UNLOCK_KEY,
  parameter logic [31:0] LOCK_KEY   = PMU_LOCK_KEY,
  parameter int          TIMEOUT    = 16,
  parameter int          CNT_W      = 5
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_data,
  output logic        done_valid,
  output logic        done_err,
  output logic        key_wr_valid,
  output logic [31:0] key_wr_data,
  input  logic        key_wr_ready,
  output logic        sleep_wr_valid,
  output logic [31:0] sleep_wr_data,
  input  logic        sleep_wr_ready,
  input  logic        unlocked_i
);

  pmu_init_state_e state_q, state_d;
  logic [31:0]     payload_q, payload_d;
  logic            err_q, err_d;
  logic            cnt_clr, cnt_en, cnt_tc;
`ifdef PMU_INIT_RETRY_EN
  logic            retry_q, retry_d;
`endif

  sirv_pmu_timeout_cnt #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .tc_o    (cnt_tc)
  );

  always_comb begin
    state_d        = state_q;
    payload_d      = payload_q;
    err_d          = err_q;
`ifdef PMU_INIT_RETRY_EN
    retry_d        = retry_q;
`endif
    cnt_clr        = 1'b0;
    cnt_en         = 1'b0;
    req_ready      = 1'b0;
    done_valid     = 1'b0;
    done_err       = 1'b0;
    key_wr_valid   = 1'b0;
    key_wr_data    = '0;
    sleep_wr_valid = 1'b0;
    sleep_wr_data  = '0;

    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          payload_d = req_data;
          state_d   = KEY_UNL;
        end
      end
      KEY_UNL: begin
        key_wr_valid = 1'b1;
        key_wr_data  = UNLOCK_KEY;
        if (key_wr_ready) begin
          cnt_clr = 1'b1;
          state_d = CHECK;
        end
      end
      // Status sampled high on the terminal cycle still wins over the timeout.
      CHECK: begin
        cnt_en = 1'b1;
        if (unlocked_i) begin
          state_d = WRITE;
        end else if (cnt_tc) begin
`ifdef PMU_INIT_RETRY_EN
          if (!retry_q) begin
            retry_d = 1'b1;
            cnt_clr = 1'b1;
            state_d = KEY_UNL;
          end else begin
            err_d   = 1'b1;
            state_d = KEY_LCK;
          end
`else
          err_d   = 1'b1;
          state_d = KEY_LCK;
`endif
        end
      end
      WRITE: begin
        sleep_wr_valid = 1'b1;
        sleep_wr_data  = payload_q;
        if (sleep_wr_ready) begin
          state_d = KEY_LCK;
        end
      end
      KEY_LCK: begin
        key_wr_valid = 1'b1;
        key_wr_data  = LOCK_KEY;
        if (key_wr_ready) begin
          state_d = RESP;
        end
      end
      RESP: begin
        done_valid = 1'b1;
        done_err   = err_q;
        err_d      = 1'b0;
`ifdef PMU_INIT_RETRY_EN
        retry_d    = 1'b0;
`endif
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      payload_q <= '0;
      err_q     <= 1'b0;
`ifdef PMU_INIT_RETRY_EN
      retry_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      payload_q <= payload_d;
      err_q     <= err_d;
`ifdef PMU_INIT_RETRY_EN
      retry_q   <= retry_d;
`endif
    end
  end

endmodule

// File: tb/tb_sirv_pmu_unlock_initiator.sv
// Directed bench for sirv_pmu_unlock_initiator: inputs change 1ns after the rising edge,
// outputs and bus transfers are observed on the falling edge.
module tb_sirv_pmu_unlock_initiator;

  localparam logic [31:0] UNL = 32'h0051_F15E;
  localparam logic [31:0] LCK = 32'h0000_0000;
  localparam logic [31:0] NONE = 32'hFFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_data;
  logic        done_valid;
  logic        done_err;
  logic        key_wr_valid;
  logic [31:0] key_wr_data;
  logic        key_wr_ready;
  logic        sleep_wr_valid;
  logic [31:0] sleep_wr_data;
  logic        sleep_wr_ready;
  logic        unlocked_i;

  int errCount = 0;
  int checkCount = 0;

  logic [31:0] keyLog[$];
  logic [31:0] sleepLog[$];
  int          sleepValidCycles = 0;
  int          doneCount = 0;
  int          stableErr = 0;
  logic        keyPend = 1'b0;
  logic        sleepPend = 1'b0;
  logic [31:0] keyPendData = '0;
  logic [31:0] sleepPendData = '0;

  sirv_pmu_unlock_initiator dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_data       (req_data),
    .done_valid     (done_valid),
    .done_err       (done_err),
    .key_wr_valid   (key_wr_valid),
    .key_wr_data    (key_wr_data),
    .key_wr_ready   (key_wr_ready),
    .sleep_wr_valid (sleep_wr_valid),
    .sleep_wr_data  (sleep_wr_data),
    .sleep_wr_ready (sleep_wr_ready),
    .unlocked_i     (unlocked_i)
  );

  always #5 clock = ~clock;

  // Bus monitor: logs completed transfers and flags any valid/data change while stalled.
  always @(negedge clock) begin
    if (!reset_n) begin
      keyPend   = 1'b0;
      sleepPend = 1'b0;
    end else begin
      if (keyPend && (!key_wr_valid || key_wr_data !== keyPendData)) stableErr++;
      if (sleepPend && (!sleep_wr_valid || sleep_wr_data !== sleepPendData)) stableErr++;
      if (key_wr_valid && key_wr_ready) keyLog.push_back(key_wr_data);
      if (sleep_wr_valid && sleep_wr_ready) sleepLog.push_back(sleep_wr_data);
      keyPend       = key_wr_valid && !key_wr_ready;
      keyPendData   = key_wr_data;
      sleepPend     = sleep_wr_valid && !sleep_wr_ready;
      sleepPendData = sleep_wr_data;
      if (sleep_wr_valid) sleepValidCycles++;
      if (done_valid) doneCount++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] keyAt(input int i);
    return (i < keyLog.size()) ? keyLog[i] : NONE;
  endfunction

  function automatic logic [31:0] sleepAt(input int i);
    return (i < sleepLog.size()) ? sleepLog[i] : NONE;
  endfunction

  task automatic clearLogs();
    keyLog.delete();
    sleepLog.delete();
    sleepValidCycles = 0;
    doneCount = 0;
    stableErr = 0;
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  // Issues one command from IDLE and plays the PMU side until done_valid.
  // unlocked_i rises unlockDelay cycles after the unlockAttempt-th unlock-key transfer (0 = never);
  // lat is the cycle index of done_valid counted from the accept edge.
  task automatic applyStimulus(input logic [31:0] data, input int unlockAttempt, input int unlockDelay,
                               input int keyStall, input int sleepStall, input bit pulseInCheck,
                               input int maxCycles, output int lat, output logic gotErr);
    int unlAcc;
    int accCycle;
    int keyLeft;
    int sleepLeft;
    bit gotDone;
    unlAcc = 0;
    accCycle = 0;
    keyLeft = keyStall;
    sleepLeft = sleepStall;
    gotDone = 1'b0;
    gotErr = 1'b0;
    lat = 0;
    clearLogs();
    req_valid = 1'b1;
    req_data = data;
    @(negedge clock);
    checkOutput("req_ready_idle", {31'd0, req_ready}, 32'd1);
    nextCycle();
    req_valid = 1'b0;
    req_data = '0;
    for (int i = 1; i <= maxCycles && !gotDone; i++) begin
      if (key_wr_valid && key_wr_data == UNL && keyLeft > 0) begin
        key_wr_ready = 1'b0;
        keyLeft--;
      end else begin
        key_wr_ready = 1'b1;
      end
      if (sleep_wr_valid && sleepLeft > 0) begin
        sleep_wr_ready = 1'b0;
        sleepLeft--;
      end else begin
        sleep_wr_ready = 1'b1;
      end
      unlocked_i = (unlockDelay > 0) && (unlAcc >= unlockAttempt) && (i >= accCycle + unlockDelay);
      if (pulseInCheck && unlAcc > 0 && i == accCycle + 1) begin
        req_valid = 1'b1;
        req_data = 32'hDEAD_BEEF;
      end else begin
        req_valid = 1'b0;
        req_data = '0;
      end
      @(negedge clock);
      if (req_valid) checkOutput("req_ready_busy", {31'd0, req_ready}, 32'd0);
      if (key_wr_valid && key_wr_ready && key_wr_data == UNL) begin
        unlAcc++;
        accCycle = i;
      end
      if (done_valid) begin
        gotDone = 1'b1;
        lat = i;
        gotErr = done_err;
      end
      nextCycle();
    end
    req_valid = 1'b0;
    req_data = '0;
    unlocked_i = 1'b0;
    key_wr_ready = 1'b1;
    sleep_wr_ready = 1'b1;
    if (!gotDone) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int lat;
    logic err;

    reset_n = 1'b0;
    req_valid = 1'b0;
    req_data = '0;
    key_wr_ready = 1'b1;
    sleep_wr_ready = 1'b1;
    unlocked_i = 1'b0;
    repeat (2) nextCycle();
    @(negedge clock);
    checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("rst_done_valid", {31'd0, done_valid}, 32'd0);
    checkOutput("rst_done_err", {31'd0, done_err}, 32'd0);
    checkOutput("rst_key_valid", {31'd0, key_wr_valid}, 32'd0);
    checkOutput("rst_sleep_valid", {31'd0, sleep_wr_valid}, 32'd0);
    checkOutput("rst_key_data", key_wr_data, 32'd0);
    checkOutput("rst_sleep_data", sleep_wr_data, 32'd0);
    nextCycle();
    reset_n = 1'b1;

    $display("[TB] nominal command");
    applyStimulus(32'h0000_00A5, 1, 1, 0, 0, 1'b0, 60, lat, err);
    checkOutput("nom_latency", lat, 32'd5);
    checkOutput("nom_err", {31'd0, err}, 32'd0);
    checkOutput("nom_key_count", keyLog.size(), 32'd2);
    checkOutput("nom_key0", keyAt(0), UNL);
    checkOutput("nom_key1", keyAt(1), LCK);
    checkOutput("nom_sleep_count", sleepLog.size(), 32'd1);
    checkOutput("nom_sleep_data", sleepAt(0), 32'h0000_00A5);
    @(negedge clock);
    checkOutput("nom_done_count", doneCount, 32'd1);
    checkOutput("nom_req_ready_back", {31'd0, req_ready}, 32'd1);
    nextCycle();

    $display("[TB] unlock never seen");
    applyStimulus(32'h0000_0001, 1, 0, 0, 0, 1'b0, 60, lat, err);
`ifdef PMU_INIT_RETRY_EN
    checkOutput("to_latency", lat, 32'd36);
    checkOutput("to_key_count", keyLog.size(), 32'd3);
    checkOutput("to_key_retry", keyAt(1), UNL);
`else
    checkOutput("to_latency", lat, 32'd19);
    checkOutput("to_key_count", keyLog.size(), 32'd2);
`endif
    checkOutput("to_err", {31'd0, err}, 32'd1);
    checkOutput("to_key_first", keyAt(0), UNL);
    checkOutput("to_key_last", keyAt(keyLog.size() - 1), LCK);
    checkOutput("to_sleep_valid_cycles", sleepValidCycles, 32'd0);

    $display("[TB] unlock on the terminal CHECK cycle");
    applyStimulus(32'h3C3C_0001, 1, 16, 0, 0, 1'b0, 60, lat, err);
    checkOutput("edge_latency", lat, 32'd20);
    checkOutput("edge_err", {31'd0, err}, 32'd0);
    checkOutput("edge_sleep_data", sleepAt(0), 32'h3C3C_0001);
    checkOutput("edge_key1", keyAt(1), LCK);

    $display("[TB] back-pressure on key and sleep writes");
    applyStimulus(32'h1234_5678, 1, 1, 7, 3, 1'b0, 60, lat, err);
    checkOutput("bp_latency", lat, 32'd15);
    checkOutput("bp_err", {31'd0, err}, 32'd0);
    checkOutput("bp_stable", stableErr, 32'd0);
    checkOutput("bp_key_count", keyLog.size(), 32'd2);
    checkOutput("bp_sleep_count", sleepLog.size(), 32'd1);
    checkOutput("bp_sleep_data", sleepAt(0), 32'h1234_5678);

    $display("[TB] request while busy, status high while idle");
    applyStimulus(32'h0000_00C3, 1, 3, 0, 0, 1'b1, 60, lat, err);
    checkOutput("busy_latency", lat, 32'd7);
    checkOutput("busy_sleep_data", sleepAt(0), 32'h0000_00C3);
    checkOutput("busy_done_count", doneCount, 32'd1);
    checkOutput("busy_key_count", keyLog.size(), 32'd2);
    clearLogs();
    unlocked_i = 1'b1;
    repeat (6) nextCycle();
    unlocked_i = 1'b0;
    @(negedge clock);
    checkOutput("idle_key_count", keyLog.size(), 32'd0);
    checkOutput("idle_sleep_valid_cycles", sleepValidCycles, 32'd0);
    checkOutput("idle_done_count", doneCount, 32'd0);
    checkOutput("idle_req_ready", {31'd0, req_ready}, 32'd1);
    nextCycle();

    $display("[TB] reset during the sleep write");
    clearLogs();
    req_valid = 1'b1;
    req_data = 32'h0000_BEEF;
    nextCycle();
    req_valid = 1'b0;
    req_data = '0;
    nextCycle();
    unlocked_i = 1'b1;
    nextCycle();
    unlocked_i = 1'b0;
    sleep_wr_ready = 1'b0;
    @(negedge clock);
    checkOutput("rw_in_write", {31'd0, sleep_wr_valid}, 32'd1);
    nextCycle();
    reset_n = 1'b0;
    nextCycle();
    reset_n = 1'b1;
    sleep_wr_ready = 1'b1;
    @(negedge clock);
    checkOutput("rw_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("rw_key_valid", {31'd0, key_wr_valid}, 32'd0);
    checkOutput("rw_sleep_valid", {31'd0, sleep_wr_valid}, 32'd0);
    checkOutput("rw_done_valid", {31'd0, done_valid}, 32'd0);
    repeat (3) nextCycle();
    checkOutput("rw_no_done", doneCount, 32'd0);
    checkOutput("rw_no_sleep", sleepLog.size(), 32'd0);
    applyStimulus(32'h0000_005A, 1, 1, 0, 0, 1'b0, 60, lat, err);
    checkOutput("rw_after_latency", lat, 32'd5);
    checkOutput("rw_after_err", {31'd0, err}, 32'd0);
    checkOutput("rw_after_sleep_data", sleepAt(0), 32'h0000_005A);

`ifdef PMU_INIT_RETRY_EN
    $display("[TB] unlock on the retried attempt");
    applyStimulus(32'h0000_0077, 2, 3, 0, 0, 1'b0, 80, lat, err);
    checkOutput("retry_latency", lat, 32'd24);
    checkOutput("retry_err", {31'd0, err}, 32'd0);
    checkOutput("retry_key_count", keyLog.size(), 32'd3);
    checkOutput("retry_key1", keyAt(1), UNL);
    checkOutput("retry_key2", keyAt(2), LCK);
    checkOutput("retry_sleep_count", sleepLog.size(), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
